tensor_walk_ctrl: RTL and testbench
===================================

// Module: tensor_walk_ctrl
// PURPOSE
//  Sequencer for a 3D tensor/cube memory (reg [DATA_W-1:0] cube[z][y][x]).
//  On start, walks every coordinate of a programmable sub-cube (x fastest, then y, then z),
//  issues one read per element to a synchronous-read memory and streams the data out
//  over a valid/ready interface, with credit-based flow control and a 2-entry output buffer.
//  Sits between the cube storage and any downstream consumer (e.g. a reduction or DMA stage).
// PARAMETERS
//  DIM_W   3  coordinate width per axis (cube is 2**DIM_W per side)
//  DATA_W  8  element width
// PORTS
//  clk        in   1       rising-edge clock
//  rst        in   1       synchronous, active-high reset
//  start      in   1       1-cycle request to begin a walk; ignored while busy=1
//  ext_z      in   DIM_W   last z index (inclusive), sampled on accepted start
//  ext_y      in   DIM_W   last y index (inclusive)
//  ext_x      in   DIM_W   last x index (inclusive)
//  busy       out  1       high from cycle after accepted start until the cycle done pulses
//  done       out  1       1-cycle pulse after the final element has been accepted downstream
//  mem_re     out  1       read strobe to cube memory
//  mem_z/y/x  out  DIM_W   read coordinate, valid when mem_re=1
//  mem_rdata  in   DATA_W  read data, valid exactly 1 cycle after mem_re
//  out_valid  out  1       output element available
//  out_ready  in   1       downstream accepts when out_valid & out_ready
//  out_data   out  DATA_W  element value
//  out_last   out  1       marks final element of the walk (qualified by out_valid)
// BEHAVIOUR
//  - Reset: state=IDLE; busy=0, done=0, mem_re=0, mem_z/y/x=0, out_valid=0, out_last=0,
//    out_data=0; buffer and in-flight count cleared. Reset mid-walk aborts: no done, no further output.
//  - States: IDLE -> RUN on start (latch ext_*, coord=0,0,0); RUN -> DRAIN in the cycle the
//    final read (coord == ext) is issued; DRAIN -> DONE when buffer empty and nothing in flight;
//    DONE -> IDLE after 1 cycle (done=1 only in DONE). start outside IDLE has no effect.
//  - Issue rule (RUN): mem_re=1 iff (fifo_count + inflight - pop) < 2, pop = out_valid & out_ready.
//    inflight is 0/1 (read issued last cycle). Coordinates advance only on issue:
//    x++; at x==ext_x: x=0, y++; at y==ext_y: y=0, z++. No wrap beyond ext_z.
//  - Data path: mem_rdata written into buffer the cycle after mem_re; out_valid = buffer non-empty;
//    out_data/out_last from buffer head; out_last tagged on the element whose read was the final one.
//  - Latency: start in cycle 0 -> mem_re cycle 1 (0,0,0) -> out_valid cycle 3.
//  - Throughput: 1 element/cycle with out_ready held 1; buffer never overflows under any
//    out_ready pattern; no element dropped or duplicated.
//  - Element count = (ext_z+1)*(ext_y+1)*(ext_x+1); ext all 0 -> exactly one element, out_last=1.
//  - out_valid stays high and out_data stable while out_ready=0 (AXI-style hold).
//  - Simultaneous buffer push and pop: both take effect; count unchanged.
// STRUCTURE
//  - Package tensor_pkg: state enum {IDLE,RUN,DRAIN,DONE}, default DIM_W/DATA_W localparams,
//    coordinate struct {z,y,x}.
//  - Sub-module tensor_skid_fifo: 2-entry FIFO of {last, data}, push/pop/count/head outputs.
//  - Top holds FSM, coordinate counters, inflight flag, credit compare.
// TESTING
//  1 Full cube, ext=7,7,7, out_ready=1 -> 512 beats, out_data == z*64+y*8+x pattern in
//    x-fastest order, out_last only on beat 512, done 1 cycle after its handshake.
//  2 ext=0,0,0 -> single beat, out_last=1, first out_valid 3 cycles after start, done follows.
//  3 ext=1,2,3, out_ready random 50% -> 24 beats in order, mem_re never issued with 2 buffered
//    and no pop, no loss/duplication.
//  4 out_ready held 0 for 20 cycles mid-walk -> at most 2 buffered, mem_re stalls, out_data stable,
//    resumes at 1 beat/cycle on release.
//  5 start pulsed while busy -> ignored, walk count unchanged; rst asserted mid-walk ->
//    all outputs reset next cycle, no done, new start works normally.

Source files
------------

// File: rtl/tensor_pkg.sv
// Shared types for the tensor walk controller: FSM states, default widths and the
// coordinate triple used for both the walk extent and the current read position.
package tensor_pkg;

    localparam int unsigned DefDimW  = 3;
    localparam int unsigned DefDataW = 8;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } state_e;

    typedef struct packed {
        logic [DefDimW-1:0] z;
        logic [DefDimW-1:0] y;
        logic [DefDimW-1:0] x;
    } coord_t;

    // x fastest, then y, then z; the caller never advances past the final coordinate.
    function automatic coord_t coord_next(input coord_t c, input coord_t ext);
        coord_t n;
        n = c;
        if (c.x != ext.x) begin
            n.x = c.x + 1'b1;
        end else begin
            n.x = '0;
            if (c.y != ext.y) begin
                n.y = c.y + 1'b1;
            end else begin
                n.y = '0;
                n.z = c.z + 1'b1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/tensor_skid_fifo.sv
// Two-entry FIFO holding {last, data} between the cube memory read port and the
// streaming output; head is presented combinationally from the read slot.
module tensor_skid_fifo
    import tensor_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              push_last,
    input  logic              pop,
    output logic [1:0]        count,
    output logic              empty,
    output logic [DATA_W-1:0] head_data,
    output logic              head_last
);

    logic [1:0][DATA_W:0] slot_q, slot_d;
    logic                 wr_ptr_q, wr_ptr_d;
    logic                 rd_ptr_q, rd_ptr_d;
    logic [1:0]           count_q, count_d;
    logic                 push_ok;
    logic                 pop_ok;

    assign empty   = (count_q == 2'd0);
    assign pop_ok  = pop & ~empty;
    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign push_ok = push & ((count_q != 2'd2) | pop_ok);

    always_comb begin
        slot_d   = slot_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            slot_d[wr_ptr_q] = {push_last, push_data};
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (pop_ok) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, push_ok} - {1'b0, pop_ok};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q   <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            slot_q   <= slot_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count     = count_q;
    assign head_data = slot_q[rd_ptr_q][DATA_W-1:0];
    assign head_last = slot_q[rd_ptr_q][DATA_W];

endmodule

// File: rtl/tensor_walk_ctrl.sv
// Walks a programmable sub-cube (x fastest), issues one synchronous memory read per element
// and streams the results over valid/ready, throttled by buffer credits.
module tensor_walk_ctrl
    import tensor_pkg::*;
#(
    // Coordinates are held in coord_t, so DIM_W must match the package width.
    parameter int unsigned DIM_W  = DefDimW,
    parameter int unsigned DATA_W = DefDataW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DIM_W-1:0]  ext_z,
    input  logic [DIM_W-1:0]  ext_y,
    input  logic [DIM_W-1:0]  ext_x,
    output logic              busy,
    output logic              done,
    output logic              mem_re,
    output logic [DIM_W-1:0]  mem_z,
    output logic [DIM_W-1:0]  mem_y,
    output logic [DIM_W-1:0]  mem_x,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);

    state_e state_q, state_d;
    coord_t ext_q, ext_d;
    coord_t coord_q, coord_d;
    logic   inflight_q, inflight_d;
    logic   inflight_last_q, inflight_last_d;

    logic [1:0]        fifo_count;
    logic              fifo_empty;
    logic [DATA_W-1:0] head_data;
    logic              head_last;
    logic              pop;
    logic [2:0]        credit;
    logic              is_last;

    assign out_valid = ~fifo_empty;
    assign pop       = out_valid & out_ready;
    // Slots that will still be occupied next cycle without a new issue.
    assign credit    = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
    assign is_last   = (coord_q == ext_q);

    always_comb begin
        state_d         = state_q;
        ext_d           = ext_q;
        coord_d         = coord_q;
        mem_re          = 1'b0;
        done            = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    ext_d   = {ext_z, ext_y, ext_x};
                    coord_d = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (credit < 3'd2) begin
                    mem_re = 1'b1;
                    if (is_last) begin
                        state_d = StDrain;
                    end else begin
                        coord_d = coord_next(coord_q, ext_q);
                    end
                end
            end
            StDrain: begin
                if (credit == 3'd0) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        inflight_d      = mem_re;
        inflight_last_d = mem_re & is_last;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= StIdle;
            ext_q           <= '0;
            coord_q         <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            ext_q           <= ext_d;
            coord_q         <= coord_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
        end
    end

    tensor_skid_fifo #(
        .DATA_W(DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_q),
        .push_data (mem_rdata),
        .push_last (inflight_last_q),
        .pop       (pop),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .head_data (head_data),
        .head_last (head_last)
    );

    assign busy     = (state_q != StIdle);
    assign mem_z    = coord_q.z;
    assign mem_y    = coord_q.y;
    assign mem_x    = coord_q.x;
    assign out_data = head_data;
    assign out_last = out_valid & head_last;

endmodule

// File: tb/tb_tensor_walk_ctrl.sv
// Self-checking bench: a cycle-level behavioural model built from element indices and
// outstanding-read arithmetic checks every DUT output each cycle.
module tb_tensor_walk_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       out_ready = 1'b0;
    logic [2:0] ext_z = '0, ext_y = '0, ext_x = '0;
    logic       busy, done, mem_re, out_valid, out_last;
    logic [2:0] mem_z, mem_y, mem_x;
    logic [7:0] mem_rdata = '0;
    logic [7:0] out_data;
    logic [7:0] cube [8][8][8];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    tensor_walk_ctrl #(
        .DIM_W  (3),
        .DATA_W (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .ext_z     (ext_z),
        .ext_y     (ext_y),
        .ext_x     (ext_x),
        .busy      (busy),
        .done      (done),
        .mem_re    (mem_re),
        .mem_z     (mem_z),
        .mem_y     (mem_y),
        .mem_x     (mem_x),
        .mem_rdata (mem_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    // Synchronous-read cube memory.
    always @(posedge clk) begin
        if (mem_re) mem_rdata <= cube[mem_z][mem_y][mem_x];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model state
    bit mon_en = 1'b0;
    bit m_active = 1'b0;
    int m_ez = 0, m_ey = 0, m_ex = 0;
    int m_total = 0, m_issued = 0, m_avail = 0, m_accepted = 0;
    int cyc = 0, start_cyc = 0, done_cyc = 0, last_hs_cyc = 0, first_valid_cyc = 0;
    int beats = 0, done_cnt = 0;
    bit first_seen = 1'b0;
    logic [7:0] last_data = '0;
    logic       last_flag = 1'b0;

    function automatic logic [8:0] idx_coord(input int idx);
        int x, y, z;
        x = idx % (m_ex + 1);
        y = (idx / (m_ex + 1)) % (m_ey + 1);
        z = idx / ((m_ex + 1) * (m_ey + 1));
        return {z[2:0], y[2:0], x[2:0]};
    endfunction

    function automatic logic [7:0] idx_data(input int idx);
        logic [8:0] c;
        c = idx_coord(idx);
        return cube[c[8:6]][c[5:3]][c[2:0]];
    endfunction

    always @(negedge clk) begin
        bit exp_valid, pop, exp_re, exp_done;
        cyc++;
        if (mon_en) begin
            exp_valid = (m_avail > m_accepted);
            pop       = exp_valid && (out_ready === 1'b1);
            exp_re    = m_active && (m_issued < m_total) &&
                        ((m_issued - m_accepted - int'(pop)) < 2);
            exp_done  = m_active && (m_accepted == m_total);

            chk("busy", 32'(busy), 32'(m_active));
            chk("done", 32'(done), 32'(exp_done));
            chk("mem_re", 32'(mem_re), 32'(exp_re));
            if (exp_re) chk("mem_coord", {23'b0, mem_z, mem_y, mem_x}, 32'(idx_coord(m_issued)));
            chk("out_valid", 32'(out_valid), 32'(exp_valid));
            if (exp_valid) begin
                chk("out_data", 32'(out_data), 32'(idx_data(m_accepted)));
                chk("out_last", 32'(out_last), 32'(m_accepted == m_total - 1));
            end else begin
                chk("out_last_idle", 32'(out_last), 32'd0);
            end

            if (out_valid && out_ready) begin
                beats++;
                last_hs_cyc = cyc;
                last_data   = out_data;
                last_flag   = out_last;
            end
            if (out_valid && !first_seen) begin
                first_seen      = 1'b1;
                first_valid_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end

            if (rst) begin
                m_active   = 1'b0;
                m_total    = 0;
                m_issued   = 0;
                m_avail    = 0;
                m_accepted = 0;
            end else begin
                m_avail    = m_issued;
                m_issued   += int'(exp_re);
                m_accepted += int'(pop);
                if (exp_done) begin
                    m_active = 1'b0;
                end else if (!m_active && start) begin
                    m_active   = 1'b1;
                    m_ez       = int'(ext_z);
                    m_ey       = int'(ext_y);
                    m_ex       = int'(ext_x);
                    m_total    = (m_ez + 1) * (m_ey + 1) * (m_ex + 1);
                    m_issued   = 0;
                    m_avail    = 0;
                    m_accepted = 0;
                    beats      = 0;
                    first_seen = 1'b0;
                    start_cyc  = cyc;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_walk(input int ez, input int ey, input int ex);
        ext_z = 3'(ez);
        ext_y = 3'(ey);
        ext_x = 3'(ex);
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // mode 0: ready held high; 1: random ready; 2: 20-cycle ready stall mid-walk
    task automatic wait_done(input int mode, input int limit);
        int dc0;
        bit got;
        dc0 = done_cnt;
        got = 1'b0;
        for (int i = 0; i < limit; i++) begin
            step();
            if (done_cnt != dc0) begin
                got = 1'b1;
                break;
            end
            if (mode == 2 && i == 30) begin
                chk("t4_stall_valid", 32'(out_valid), 32'd1);
                chk("t4_stall_no_read", 32'(mem_re), 32'd0);
            end
            case (mode)
                1:       out_ready = 1'($urandom_range(0, 1));
                2:       out_ready = !(i >= 10 && i < 30);
                default: out_ready = 1'b1;
            endcase
        end
        if (!got) chk("walk_timeout", 32'd0, 32'd1);
        out_ready = 1'b1;
    endtask

    initial begin
        int dc;
        for (int z = 0; z < 8; z++)
            for (int y = 0; y < 8; y++)
                for (int x = 0; x < 8; x++)
                    cube[z][y][x] = 8'(z * 64 + y * 8 + x);

        step();
        mon_en = 1'b1;
        step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mem_re", 32'(mem_re), 32'd0);
        chk("rst_coord", {23'b0, mem_z, mem_y, mem_x}, 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        rst = 1'b0;
        step();

        // Full cube at full rate
        out_ready = 1'b1;
        dc = done_cnt;
        start_walk(7, 7, 7);
        wait_done(0, 2000);
        chk("t1_beats", beats, 512);
        chk("t1_last_data", 32'(last_data), 32'hFF);
        chk("t1_last_flag", 32'(last_flag), 32'd1);
        chk("t1_done_after_hs", done_cyc - last_hs_cyc, 1);
        chk("t1_total_cycles", done_cyc - start_cyc, 515);
        chk("t1_done_count", done_cnt - dc, 1);
        step();

        for (int z = 0; z < 8; z++)
            for (int y = 0; y < 8; y++)
                for (int x = 0; x < 8; x++)
                    cube[z][y][x] = 8'($urandom);

        // Single element
        start_walk(0, 0, 0);
        wait_done(0, 50);
        chk("t2_beats", beats, 1);
        chk("t2_first_valid_lat", first_valid_cyc - start_cyc, 3);
        chk("t2_last_flag", 32'(last_flag), 32'd1);
        chk("t2_done_lat", done_cyc - start_cyc, 4);
        step();

        // Random backpressure
        start_walk(1, 2, 3);
        wait_done(1, 400);
        chk("t3_beats", beats, 24);
        step();

        // Long stall mid-walk
        start_walk(3, 3, 3);
        wait_done(2, 400);
        chk("t4_beats", beats, 64);
        step();

        // Start while busy is ignored
        dc = done_cnt;
        start_walk(2, 2, 2);
        repeat (4) step();
        start_walk(7, 7, 7);
        wait_done(0, 200);
        chk("t5_beats_ignored_start", beats, 27);
        chk("t5_done_count", done_cnt - dc, 1);
        repeat (3) step();

        // Reset mid-walk aborts, then a fresh walk runs normally
        start_walk(2, 2, 2);
        repeat (8) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_valid", 32'(out_valid), 32'd0);
        chk("t5_rst_mem_re", 32'(mem_re), 32'd0);
        chk("t5_rst_data", 32'(out_data), 32'd0);
        chk("t5_rst_last", 32'(out_last), 32'd0);
        dc = done_cnt;
        repeat (40) step();
        chk("t5_no_done_after_rst", done_cnt, dc);
        start_walk(1, 1, 1);
        wait_done(1, 200);
        chk("t5_beats_after_rst", beats, 8);
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
